// File: rtl/t05_hist_dump.sv
// Histogram read-out: scans all count bins in order and streams one (symbol, count) pair per nonzero bin.
// Define CLEAR_ON_READ_EN to zero each presented bin in the SRAM right after its pair is accepted.
module t05_hist_dump #(
  parameter int ADDR_W   = 8,
  parameter int CNT_W    = 32,
  parameter int SRAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  total_i,
  output logic              sram_rd_en,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [CNT_W-1:0]  sram_rdata,
  output logic              sram_wr_en,
  output logic [CNT_W-1:0]  sram_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_sym,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              sum_err
);

  localparam int WC_W = (SRAM_LAT > 1) ? $clog2(SRAM_LAT) : 1;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    PRESENT,
    CLEAR,
    FIN
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W:0]    acc;
  logic [CNT_W-1:0]  total;
  logic [WC_W-1:0]   wait_cnt;
  logic              sum_err_q;
`ifdef CLEAR_ON_READ_EN
  logic              stop;
`endif

  logic [CNT_W:0] acc_next;
  logic           is_last;
  logic           at_max;
  logic           rd_done;

  // acc carries one extra bit so an over-count can never wrap back onto total
  assign acc_next = acc + {1'b0, cnt};
  assign is_last  = (acc_next == {1'b0, total});
  assign at_max   = (addr == ADDR_MAX);
  assign rd_done  = (wait_cnt == WC_W'(SRAM_LAT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    sram_rd_en = 1'b0;
    sram_wr_en = 1'b0;
    out_valid  = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = (total_i == '0) ? FIN : ISSUE;
      end
      ISSUE: begin
        sram_rd_en = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (rd_done) begin
          if (sram_rdata == '0) state_next = at_max ? FIN : ISSUE;
          else                  state_next = PRESENT;
        end
      end
      PRESENT: begin
        out_valid = 1'b1;
        if (out_ready) begin
`ifdef CLEAR_ON_READ_EN
          state_next = CLEAR;
`else
          state_next = (is_last || at_max) ? FIN : ISSUE;
`endif
        end
      end
      CLEAR: begin
`ifdef CLEAR_ON_READ_EN
        sram_wr_en = 1'b1;
        state_next = stop ? FIN : ISSUE;
`else
        state_next = IDLE;
`endif
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Scan datapath: bin address, captured count, running sum and the latched total
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr      <= '0;
      cnt       <= '0;
      acc       <= '0;
      total     <= '0;
      wait_cnt  <= '0;
      sum_err_q <= 1'b0;
`ifdef CLEAR_ON_READ_EN
      stop      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            total     <= total_i;
            acc       <= '0;
            addr      <= '0;
            sum_err_q <= 1'b0;
          end
        end
        ISSUE: wait_cnt <= '0;
        WAIT: begin
          if (!rd_done) begin
            wait_cnt <= wait_cnt + 1'b1;
          end else begin
            cnt <= sram_rdata;
            if (sram_rdata == '0 && !at_max) addr <= addr + 1'b1;
          end
        end
        PRESENT: begin
          if (out_ready) begin
            acc <= acc_next;
`ifdef CLEAR_ON_READ_EN
            stop <= is_last || at_max;
`else
            if (!(is_last || at_max)) addr <= addr + 1'b1;
`endif
          end
        end
        CLEAR: begin
`ifdef CLEAR_ON_READ_EN
          if (!stop) addr <= addr + 1'b1;
`endif
        end
        FIN: begin
          if (acc != {1'b0, total}) sum_err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The address register doubles as the clear-write target, since it only advances after the write
  assign sram_addr  = addr;
  assign sram_wdata = '0;
  assign out_sym    = out_valid ? addr : '0;
  assign out_cnt    = out_valid ? cnt : '0;
  assign out_last   = out_valid && is_last;
  assign busy       = (state != IDLE);
  assign sum_err    = sum_err_q;

endmodule

// File: tb/tb_t05_hist_dump.sv
// Self-checking bench for t05_hist_dump: behavioural SRAM, pair scoreboard and a table of scan scenarios.
// Build with CLEAR_ON_READ_EN defined to exercise the clear-on-read variant.
module tb_t05_hist_dump;

`ifdef CLEAR_ON_READ_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] total_i;
  logic        sram_rd_en;
  logic [7:0]  sram_addr;
  logic [31:0] sram_rdata;
  logic        sram_wr_en;
  logic [31:0] sram_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_sym;
  logic [31:0] out_cnt;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        sum_err;

  always #5 clk = ~clk;

  t05_hist_dump dut (
    .clk(clk), .rst(rst), .start(start), .total_i(total_i),
    .sram_rd_en(sram_rd_en), .sram_addr(sram_addr), .sram_rdata(sram_rdata),
    .sram_wr_en(sram_wr_en), .sram_wdata(sram_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym),
    .out_cnt(out_cnt), .out_last(out_last), .busy(busy), .done(done), .sum_err(sum_err)
  );

  // One-cycle-latency SRAM holding the count bins
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (sram_rd_en) sram_rdata <= mem[sram_addr];
    if (sram_wr_en) mem[sram_addr] = sram_wdata;
  end

  typedef struct {
    logic [7:0]  sym;
    logic [31:0] cnt;
    logic        last;
  } pair_t;

  typedef struct {
    logic [7:0]  s0;
    logic [31:0] c0;
    logic [7:0]  s1;
    logic [31:0] c1;
    logic [31:0] total;
    int          ready_mode;
    int          exp_pairs;
    logic        exp_err;
    int          exp_reads;
  } vec_t;

  pair_t exp_q[$];
  int checks = 0;
  int errors = 0;

  int cyc = 0, reads = 0, wr_count = 0, done_seen = 0, pairs_seen = 0;
  int last_hs_cyc = -1, done_cyc = -1, first_addr = -1;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_sym;
  logic [31:0] prev_cnt;
  logic        prev_last;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: strobes, stall stability, handshakes against the scoreboard, done pulses
  always @(negedge clk) begin
    pair_t p;
    cyc++;
    if (sram_rd_en) begin
      if (reads == 0) first_addr = int'(sram_addr);
      reads++;
    end
    if (sram_rd_en || sram_wr_en) check_output("rd_wr_exclusive", 64'(sram_rd_en & sram_wr_en), 0);
    if (sram_wr_en) begin
      wr_count++;
      check_output("clear_wdata", 64'(sram_wdata), 0);
    end
    if (prev_stall && rst) begin
      check_output("stall_valid", 64'(out_valid), 1);
      check_output("stall_sym", 64'(out_sym), 64'(prev_sym));
      check_output("stall_cnt", 64'(out_cnt), 64'(prev_cnt));
      check_output("stall_last", 64'(out_last), 64'(prev_last));
    end
    if (out_valid && out_ready) begin
      pairs_seen++;
      check_output("pending_pairs", 64'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        p = exp_q.pop_front();
        check_output("pair_sym", 64'(out_sym), 64'(p.sym));
        check_output("pair_cnt", 64'(out_cnt), 64'(p.cnt));
        check_output("pair_last", 64'(out_last), 64'(p.last));
      end
      if (out_last) last_hs_cyc = cyc;
    end
    prev_stall = out_valid && !out_ready && rst;
    prev_sym   = out_sym;
    prev_cnt   = out_cnt;
    prev_last  = out_last;
    if (done) begin
      done_seen++;
      done_cyc = cyc;
    end
  end

  task automatic load_bins(input vec_t v);
    for (int a = 0; a < 256; a++) mem[a] = 32'd0;
    if (v.c0 != 0) mem[v.s0] = v.c0;
    if (v.c1 != 0) mem[v.s1] = v.c1;
  endtask

  // Drives one scan and checks it; the model derives expected pairs from the SRAM image
  task automatic apply_stimulus(input vec_t v);
    pair_t       p;
    logic [32:0] s;
    logic        model_err;
    exp_q.delete();
    s = '0;
    if (v.total != 0) begin
      for (int a = 0; a < 256; a++) begin
        if (mem[a] != 0) begin
          p.sym  = 8'(a);
          p.cnt  = mem[a];
          p.last = ((s + {1'b0, mem[a]}) == {1'b0, v.total});
          exp_q.push_back(p);
          s = s + {1'b0, mem[a]};
          if (p.last) break;
        end
      end
    end
    model_err  = (s != {1'b0, v.total});
    reads      = 0;
    wr_count   = 0;
    done_seen  = 0;
    pairs_seen = 0;
    last_hs_cyc = -1;
    done_cyc   = -1;
    first_addr = -1;
    out_ready  = (v.ready_mode == 0);
    start      = 1'b1;
    total_i    = v.total;
    @(posedge clk); #1;
    start = 1'b0;
    check_output("busy_after_start", 64'(busy), 1);
    check_output("sum_err_cleared", 64'(sum_err), 0);
    for (int c = 0; c < 4000 && done_seen == 0; c++) begin
      if (v.ready_mode == 1) out_ready = (c % 3 == 2);
      if (v.ready_mode == 1 && c == 10) begin
        start   = 1'b1;
        total_i = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check_output("done_within_budget", 64'(done_seen != 0), 1);
    repeat (2) @(posedge clk);
    #1;
    check_output("done_count", 64'(done_seen), 1);
    check_output("busy_after_done", 64'(busy), 0);
    check_output("sum_err_table", 64'(sum_err), 64'(v.exp_err));
    check_output("sum_err_model", 64'(sum_err), 64'(model_err));
    check_output("pair_count", 64'(pairs_seen), 64'(v.exp_pairs));
    check_output("pairs_left", 64'(exp_q.size()), 0);
    check_output("read_count", 64'(reads), 64'(v.exp_reads));
    if (v.exp_reads > 0) check_output("first_read_addr", 64'(first_addr), 0);
    check_output("clear_writes", 64'(wr_count), CLR ? 64'(v.exp_pairs) : 64'd0);
    if (last_hs_cyc >= 0) check_output("done_gap", 64'(done_cyc - last_hs_cyc), CLR ? 64'd2 : 64'd1);
    out_ready = 1'b1;
  endtask

  initial begin
    vec_t tbl[6];
    vec_t v;
    tbl[0] = '{8'h41, 32'd3, 8'h42, 32'd1, 32'd4, 0, 2, 1'b0, 67};
    tbl[1] = '{8'h00, 32'd0, 8'h00, 32'd0, 32'd0, 0, 0, 1'b0, 0};
    tbl[2] = '{8'h00, 32'd2, 8'hFF, 32'd5, 32'd7, 1, 2, 1'b0, 256};
    tbl[3] = '{8'h10, 32'd2, 8'h00, 32'd0, 32'd5, 0, 1, 1'b1, 256};
    tbl[4] = '{8'h05, 32'd4, 8'h06, 32'd9, 32'd3, 0, 2, 1'b1, 256};
    tbl[5] = '{8'h41, 32'd3, 8'h42, 32'd1, 32'd4, 1, 2, 1'b0, 67};

    rst       = 1'b0;
    start     = 1'b0;
    total_i   = 32'd0;
    out_ready = 1'b1;
    for (int a = 0; a < 256; a++) mem[a] = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_state", 64'({out_valid, busy, done, sum_err, sram_rd_en, sram_wr_en,
                                      sram_addr, out_sym, out_cnt, out_last}), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      $display("[TB] scan vector %0d, total=%0d", i, tbl[i].total);
      load_bins(tbl[i]);
      apply_stimulus(tbl[i]);
    end

    // Rescan the same image without reloading: clear-on-read leaves nothing behind
    load_bins(tbl[0]);
    apply_stimulus(tbl[0]);
    check_output("bin41_after_scan", 64'(mem[8'h41]), CLR ? 64'd0 : 64'd3);
    check_output("bin42_after_scan", 64'(mem[8'h42]), CLR ? 64'd0 : 64'd1);
    v = tbl[0];
    v.exp_pairs = CLR ? 0 : 2;
    v.exp_err   = CLR ? 1'b1 : 1'b0;
    v.exp_reads = CLR ? 256 : 67;
    apply_stimulus(v);

    // Reset asserted while a pair is held at 0x30
    v = '{8'h30, 32'd9, 8'h00, 32'd0, 32'd9, 0, 1, 1'b0, 49};
    load_bins(v);
    exp_q.delete();
    out_ready = 1'b0;
    start     = 1'b1;
    total_i   = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 200 && !out_valid; c++) begin
      @(posedge clk); #1;
    end
    check_output("reset_case_present", 64'(out_valid), 1);
    check_output("reset_case_sym", 64'(out_sym), 64'h30);
    done_seen = 0;
    rst = 1'b0;
    #1;
    check_output("reset_outputs", 64'({out_valid, busy, done, sum_err, sram_rd_en, sram_wr_en,
                                        sram_addr, out_sym, out_cnt, out_last}), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    check_output("no_done_on_reset", 64'(done_seen), 0);
    @(posedge clk); #1;
    apply_stimulus(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
